// File: rtl/dram_image_banked.sv
// dram_image_banked: banked multi-port image memory.
// Per-bank round-robin arbitration, registered read return with rvalid.
module dram_image_banked #(
    parameter int NPORTS = 10,
    parameter int AW     = 18,
    parameter int DW     = 16,
    parameter int NBANKS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NPORTS-1:0]    req,
    input  logic [NPORTS-1:0]    we,
    input  logic [NPORTS*AW-1:0] addr,
    input  logic [NPORTS*DW-1:0] wdata,
    output logic [NPORTS-1:0]    gnt,
    output logic [NPORTS-1:0]    rvalid,
    output logic [NPORTS*DW-1:0] rdata
);

    localparam int BW   = $clog2(NBANKS);
    localparam int BWI  = (BW > 0) ? BW : 1;
    localparam int RW   = AW - BW;
    localparam int RWI  = (RW > 0) ? RW : 1;
    localparam int ROWS = 1 << RW;
    localparam int PW   = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    // Per-port address decode.
    logic [BWI-1:0]       pbank [NPORTS];
    logic [RWI-1:0]       prow  [NPORTS];

    // Per-bank arbitration state and the access each bank performs.
    logic [PW-1:0]        ptr_q [NBANKS];
    logic [PW-1:0]        ptr_d [NBANKS];
    logic [PW-1:0]        gsel  [NBANKS];
    logic [NBANKS-1:0]    gval;
    logic [NBANKS-1:0]    bwe;
    logic [RWI-1:0]       brow  [NBANKS];
    logic [DW-1:0]        bwd   [NBANKS];
    logic [NBANKS*DW-1:0] bank_rd;

    // Registered read return.
    logic [NPORTS-1:0]    rvalid_q;
    logic [NPORTS-1:0]    rvalid_d;
    logic [NPORTS*DW-1:0] rdata_q;
    logic [NPORTS*DW-1:0] rdata_d;

    // Arbitration scan helpers.
    int                   idx;
    logic [PW-1:0]        cand;

    // Split each port address into bank (low bits) and row (high bits).
    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            pbank[i] = BWI'(addr[i*AW +: AW]) & BWI'(NBANKS - 1);
            prow[i]  = RWI'(addr[i*AW +: AW] >> BW);
        end
    end

    // Round-robin grant per bank, starting the scan at that bank's pointer.
    always_comb begin
        gnt  = '0;
        gval = '0;
        bwe  = '0;
        idx  = 0;
        cand = '0;
        for (int b = 0; b < NBANKS; b++) begin
            gsel[b]  = '0;
            brow[b]  = '0;
            bwd[b]   = '0;
            ptr_d[b] = ptr_q[b];
        end
        for (int b = 0; b < NBANKS; b++) begin
            for (int k = 0; k < NPORTS; k++) begin
                idx = int'(ptr_q[b]) + k;
                if (idx >= NPORTS) begin
                    idx = idx - NPORTS;
                end
                cand = PW'(idx);
                if (!rst && !gval[b] && req[cand] &&
                    pbank[cand] == BWI'(b)) begin
                    gval[b] = 1'b1;
                    gsel[b] = cand;
                end
            end
            if (gval[b]) begin
                gnt[gsel[b]] = 1'b1;
                bwe[b]       = we[gsel[b]];
                brow[b]      = prow[gsel[b]];
                bwd[b]       = wdata[int'(gsel[b])*DW +: DW];
                ptr_d[b]     = (int'(gsel[b]) == NPORTS - 1) ?
                               '0 : gsel[b] + 1'b1;
            end
        end
    end

    // Pointers advance past the winner only on a grant; idle banks hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NBANKS; b++) begin
                ptr_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NBANKS; b++) begin
                ptr_q[b] <= ptr_d[b];
            end
        end
    end

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        logic [DW-1:0] mem [ROWS];

        // Single write port per bank; contents survive reset.
        always_ff @(posedge clk) begin
            if (bwe[b]) begin
                mem[brow[b]] <= bwd[b];
            end
        end

        assign bank_rd[b*DW +: DW] = mem[brow[b]];
    end

    // Route each bank's read word to the port it granted.
    always_comb begin
        rvalid_d = '0;
        rdata_d  = rdata_q;
        for (int b = 0; b < NBANKS; b++) begin
            if (gval[b] && !bwe[b]) begin
                rvalid_d[gsel[b]] = 1'b1;
                rdata_d[int'(gsel[b])*DW +: DW] = bank_rd[b*DW +: DW];
            end
        end
    end

    // Read return registers; reset kills any in-flight rvalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

endmodule
